// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// FSM control unit that takes one instruction at a time over a valid/ready
// handshake and walks it through DECODE, EXEC, MEM and WB. It drives the
// register file, the ALU and a variable-latency data memory (req/ack).
// Optional build macro MULTICYCLE_CU_PERF_EN adds the cycle_cnt/retire_cnt
// performance counters. The default build leaves them out.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready for an instruction; the only state with busy=0
// S_DECODE | register read data valid; operands latched
// S_EXEC   | ALU operands presented, branch/jump resolved, ALU result latched
// S_MEM    | data-memory request held until ack or timeout
// S_WB     | one-cycle register write-back and retire

module multicycle_control_unit #(
    parameter int DATA_W       = 32,
    parameter int OPC_W        = 6,
    parameter int SIGN_EXT_IMM = 1,
    parameter int MEM_TIMEOUT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instruction,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    output logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] regin1,
    input  logic [DATA_W-1:0] regin2,
    input  logic [DATA_W-1:0] aluin,
    output logic [OPC_W-1:0]  alu_op,
    output logic [DATA_W-1:0] aluout1,
    output logic [DATA_W-1:0] aluout2,
    output logic              branch,
    output logic [DATA_W-1:0] offset,
    output logic              write_enable,
    output logic [DATA_W-1:0] regout,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              busy,
    output logic              err,
    output logic              retire
`ifdef MULTICYCLE_CU_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       retire_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    // The wait timer counts down from MEM_TIMEOUT-1 so that terminal count
    // (zero) lines up with the MEM_TIMEOUT-th cycle spent in MEM.
    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_INIT = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t              state_q, state_d;
    logic [31:0]         instr_q;
    logic [DATA_W-1:0]   op1_q, op2_q, alu_q, mem_q;
    logic [TW-1:0]       wait_q;

    logic [31:0]         opc;
    logic [DATA_W-1:0]   imm_sext, imm_zext, imm_alu, jmp_target;
    logic                is_imm, is_load, is_store, is_mem, is_br, is_br_retire;
    logic                timeout_hit;

    assign rs_addr = instr_q[25:21];
    assign rt_addr = instr_q[20:16];
    assign rd_addr = instr_q[15:11];
    assign alu_op  = instr_q[31:32-OPC_W];
    assign opc     = 32'(alu_op);

    assign imm_sext   = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
    assign imm_zext   = {{(DATA_W-16){1'b0}}, instr_q[15:0]};
    // Opcode 24 (upper/logical immediate) always takes the raw bit pattern.
    assign imm_alu    = (SIGN_EXT_IMM != 0 && opc != 32'd24) ? imm_sext : imm_zext;
    assign jmp_target = {{(DATA_W-26){1'b0}}, instr_q[25:0]};

    assign is_imm       = (opc == 32'd4)  || (opc == 32'd5)  || (opc == 32'd8) ||
                          (opc == 32'd9)  || (opc == 32'd10) || (opc == 32'd11) ||
                          (opc == 32'd24);
    assign is_load      = (opc == 32'd12);
    assign is_store     = (opc == 32'd13);
    assign is_mem       = is_load || is_store;
    assign is_br        = (opc >= 32'd14) && (opc <= 32'd22);
    // Opcode 22 (link jump) redirects but still needs a write-back.
    assign is_br_retire = (opc >= 32'd14) && (opc <= 32'd21);

    assign timeout_hit  = (MEM_TIMEOUT > 0) && (wait_q == '0);

    assign aluout1 = op1_q;
    assign aluout2 = is_imm ? imm_alu : op2_q;

    // Redirect target selection by branch/jump flavour.
    always_comb begin
        offset = '0;
        if (opc == 32'd20 || opc == 32'd22) begin
            offset = jmp_target;
        end else if (opc == 32'd21) begin
            offset = op1_q;
        end else if (opc >= 32'd14 && opc <= 32'd19) begin
            offset = imm_sext;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_d      = state_q;
        instr_ready  = 1'b0;
        busy         = 1'b1;
        branch       = 1'b0;
        write_enable = 1'b0;
        regout       = '0;
        dm_req       = 1'b0;
        dm_we        = 1'b0;
        dm_addr      = '0;
        dm_wdata     = '0;
        err          = 1'b0;
        retire       = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                branch = is_br;
                if (is_mem) begin
                    state_d = S_MEM;
                end else if (is_br_retire) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dm_req   = 1'b1;
                dm_we    = is_store;
                dm_addr  = is_store ? (op2_q + imm_sext) : (op1_q + imm_sext);
                dm_wdata = is_store ? op1_q : '0;
                // An ack in the timeout cycle still completes the access.
                if (dm_ack) begin
                    if (is_store) begin
                        retire  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                write_enable = 1'b1;
                regout       = is_load ? mem_q : alu_q;
                retire       = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Instruction, operand, result and wait-timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            alu_q   <= '0;
            mem_q   <= '0;
            wait_q  <= '0;
        end else begin
            if (state_q == S_IDLE && instr_valid) begin
                instr_q <= instruction;
            end
            if (state_q == S_DECODE) begin
                op1_q <= regin1;
                op2_q <= regin2;
            end
            if (state_q == S_EXEC) begin
                alu_q  <= aluin;
                wait_q <= WAIT_INIT;
            end
            if (state_q == S_MEM) begin
                if (dm_ack && is_load) begin
                    mem_q <= dm_rdata;
                end else if (wait_q != '0) begin
                    wait_q <= wait_q - 1'b1;
                end
            end
        end
    end

`ifdef MULTICYCLE_CU_PERF_EN
    // Busy-cycle and retired-instruction counters, free-running and wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (busy) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (retire) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
